// File: rtl/crom_pixel_shifter.sv
// crom_pixel_shifter
//   Two-stage pixel serialiser for character-ROM words. A loaded word first
//   lands in a hold register, then moves into the shift register. From there
//   it is emitted one 4-bit pixel per PIX_CE. While the current word is
//   shifting, the hold register accepts the next word. The transfer happens
//   on the same edge that emits pixel 7, so consecutive words leave without
//   a gap.
//
// Ports
//   CLK        single clock for all logic
//   nRESET     synchronous, active-low reset
//   LOAD       one-cycle strobe: CR_DOUBLE / FLIP / PAL are valid
//   CR_DOUBLE  8 pixels of 4 bits, pixel i = CR_DOUBLE[63-4i -: 4]
//   FLIP       horizontal flip for the loaded word
//   PAL        palette attribute for the loaded word
//   PIX_CE     pixel clock enable, at most one pixel per asserted cycle
//   CLR_OVR    clears OVERRUN (a simultaneous drop wins)
//   PIX_OUT    emitted pixel code
//   PIX_PAL    palette of the emitted pixel
//   PIX_VALID  PIX_OUT / PIX_PAL updated this cycle
//   PIX_OPAQUE PIX_OUT != TRANSPARENT, only while PIX_VALID
//   HOLD_FULL  hold register occupied
//   BUSY       shifter in SHIFT state
//   OVERRUN    sticky: a LOAD was dropped because hold was full
module crom_pixel_shifter #(
   parameter logic [3:0] TRANSPARENT = 4'h0
) (
   input  logic        CLK,
   input  logic        nRESET,
   input  logic        LOAD,
   input  logic [63:0] CR_DOUBLE,
   input  logic        FLIP,
   input  logic [7:0]  PAL,
   input  logic        PIX_CE,
   input  logic        CLR_OVR,
   output logic [3:0]  PIX_OUT,
   output logic [7:0]  PIX_PAL,
   output logic        PIX_VALID,
   output logic        PIX_OPAQUE,
   output logic        HOLD_FULL,
   output logic        BUSY,
   output logic        OVERRUN
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t      state, state_nxt;

   logic [63:0] hold_data;
   logic        hold_flip;
   logic [7:0]  hold_pal;
   logic        hold_vld;

   logic [63:0] sh_data;
   logic        sh_flip;
   logic [7:0]  sh_pal;
   logic [2:0]  idx;

   logic        emit, last, transfer, load_ok, drop;
   logic [2:0]  pix_sel;
   logic [5:0]  base;
   logic [3:0]  pix_cur;

   always_comb begin
      emit     = (state == SHIFT) && PIX_CE;
      last     = emit && (idx == 3'd7);
      // Hold moves into the shifter either when idle or on the last-pixel
      // edge. The second case keeps back-to-back words gapless.
      transfer = hold_vld && ((state == IDLE) || last);
      load_ok  = LOAD && (!hold_vld || transfer);
      drop     = LOAD && !load_ok;
      // A flipped word reads its pixels in reverse order: 7 - idx == ~idx.
      pix_sel  = sh_flip ? ~idx : idx;
      base     = 6'd63 - {1'b0, pix_sel, 2'b00};
      pix_cur  = sh_data[base -: 4];

      state_nxt = state;
      case (state)
         IDLE:    if (hold_vld) state_nxt = SHIFT;
         SHIFT:   if (last && !hold_vld) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         state      <= IDLE;
         hold_data  <= '0;
         hold_flip  <= 1'b0;
         hold_pal   <= '0;
         hold_vld   <= 1'b0;
         sh_data    <= '0;
         sh_flip    <= 1'b0;
         sh_pal     <= '0;
         idx        <= '0;
         PIX_OUT    <= '0;
         PIX_PAL    <= '0;
         PIX_VALID  <= 1'b0;
         PIX_OPAQUE <= 1'b0;
         OVERRUN    <= 1'b0;
      end else begin
         state <= state_nxt;

         if (load_ok) begin
            hold_data <= CR_DOUBLE;
            hold_flip <= FLIP;
            hold_pal  <= PAL;
            hold_vld  <= 1'b1;
         end else if (transfer) begin
            hold_vld  <= 1'b0;
         end

         if (transfer) begin
            sh_data <= hold_data;
            sh_flip <= hold_flip;
            sh_pal  <= hold_pal;
            idx     <= '0;
         end else if (emit) begin
            idx     <= idx + 3'd1;
         end

         PIX_VALID  <= emit;
         PIX_OPAQUE <= emit && (pix_cur != TRANSPARENT);
         if (emit) begin
            PIX_OUT <= pix_cur;
            PIX_PAL <= sh_pal;
         end

         OVERRUN <= drop | (OVERRUN & ~CLR_OVR);
      end
   end

   assign BUSY      = (state == SHIFT);
   assign HOLD_FULL = hold_vld;

endmodule

// File: tb/tb_crom_pixel_shifter.sv
// Testbench for crom_pixel_shifter. Each loaded word pushes its expected
// pixels onto a queue. A negedge monitor pops one entry per PIX_VALID and
// compares it against the DUT outputs.
module tb_crom_pixel_shifter;

   logic        CLK = 1'b0;
   logic        nRESET, LOAD, FLIP, PIX_CE, CLR_OVR;
   logic [63:0] CR_DOUBLE;
   logic [7:0]  PAL;
   logic [3:0]  PIX_OUT;
   logic [7:0]  PIX_PAL;
   logic        PIX_VALID, PIX_OPAQUE, HOLD_FULL, BUSY, OVERRUN;

   int ncmp = 0;
   int nerr = 0;
   int run = 0;
   int maxrun = 0;

   typedef struct {
      logic [3:0] pix;
      logic [7:0] pal;
   } exp_t;
   exp_t q[$];

   typedef struct {
      logic [63:0] data;
      logic        flip;
      logic [7:0]  pal;
      logic [31:0] exp;   // expected pixel codes in emission order, MSB first
   } vec_t;

   crom_pixel_shifter dut (
      .CLK(CLK), .nRESET(nRESET), .LOAD(LOAD), .CR_DOUBLE(CR_DOUBLE),
      .FLIP(FLIP), .PAL(PAL), .PIX_CE(PIX_CE), .CLR_OVR(CLR_OVR),
      .PIX_OUT(PIX_OUT), .PIX_PAL(PIX_PAL), .PIX_VALID(PIX_VALID),
      .PIX_OPAQUE(PIX_OPAQUE), .HOLD_FULL(HOLD_FULL), .BUSY(BUSY),
      .OVERRUN(OVERRUN)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_word(input logic [31:0] exp, input logic [7:0] pal);
      exp_t e;
      for (int k = 0; k < 8; k++) begin
         e.pix = exp[31-4*k -: 4];
         e.pal = pal;
         q.push_back(e);
      end
   endtask

   task automatic load_word(input logic [63:0] d, input logic f, input logic [7:0] p);
      LOAD = 1'b1; CR_DOUBLE = d; FLIP = f; PAL = p;
      tick();
      LOAD = 1'b0;
   endtask

   // Wait until the shifter, the hold register and the scoreboard are all
   // empty. Give up after a bounded number of cycles.
   task automatic drain(input string name);
      int n = 0;
      while ((BUSY || HOLD_FULL || q.size() != 0) && n < 60) begin
         tick();
         n++;
      end
      check({name, "_drain_timeout"}, (n >= 60) ? 32'd1 : 32'd0, 32'd0);
      tick();
   endtask

   // Scoreboard monitor
   always @(negedge CLK) begin
      exp_t e;
      if (PIX_VALID === 1'b1) begin
         run++;
         if (run > maxrun) maxrun = run;
         if (q.size() == 0) begin
            check("unexpected_pixel", {28'd0, PIX_OUT}, 32'hFFFF_FFFF);
         end else begin
            e = q.pop_front();
            check("pix_out", {28'd0, PIX_OUT}, {28'd0, e.pix});
            check("pix_pal", {24'd0, PIX_PAL}, {24'd0, e.pal});
            check("pix_opaque", {31'd0, PIX_OPAQUE}, {31'd0, (e.pix != 4'h0)});
         end
      end else begin
         run = 0;
         check("opaque_unqualified", {31'd0, PIX_OPAQUE}, 32'd0);
      end
   end

   initial begin
      vec_t vecs[4];
      int npix;
      logic ce;

      vecs[0] = '{64'h0123456789ABCDEF, 1'b0, 8'h5A, 32'h01234567};
      vecs[1] = '{64'h0123456789ABCDEF, 1'b1, 8'h5A, 32'h76543210};
      vecs[2] = '{64'hFEDCBA9876543210, 1'b0, 8'hC3, 32'hFEDCBA98};
      vecs[3] = '{64'h20F00F03DEADBEEF, 1'b1, 8'h01, 32'h30F00F02};

      nRESET = 1'b0; LOAD = 1'b0; FLIP = 1'b0; PIX_CE = 1'b0; CLR_OVR = 1'b0;
      CR_DOUBLE = '0; PAL = '0;
      tick(); tick();
      check("rst_valid",   {31'd0, PIX_VALID},  32'd0);
      check("rst_out",     {28'd0, PIX_OUT},    32'd0);
      check("rst_pal",     {24'd0, PIX_PAL},    32'd0);
      check("rst_opaque",  {31'd0, PIX_OPAQUE}, 32'd0);
      check("rst_hold",    {31'd0, HOLD_FULL},  32'd0);
      check("rst_busy",    {31'd0, BUSY},       32'd0);
      check("rst_overrun", {31'd0, OVERRUN},    32'd0);
      nRESET = 1'b1;
      tick();

      // Table-driven words with PIX_CE held high. Also checks load latency.
      PIX_CE = 1'b1;
      for (int v = 0; v < 4; v++) begin
         push_word(vecs[v].exp, vecs[v].pal);
         load_word(vecs[v].data, vecs[v].flip, vecs[v].pal);
         check("lat_hold_full", {31'd0, HOLD_FULL}, 32'd1);
         check("lat_busy0",     {31'd0, BUSY},      32'd0);
         tick();
         check("lat_busy1",     {31'd0, BUSY},      32'd1);
         check("lat_hold_free", {31'd0, HOLD_FULL}, 32'd0);
         tick();
         check("lat_first_valid", {31'd0, PIX_VALID}, 32'd1);
         drain("table");
      end

      // Back-to-back: two LOADs 4 cycles apart must give 16 gapless pixels.
      maxrun = 0;
      push_word(32'h01234567, 8'h11);
      push_word(32'hFEDCBA98, 8'h22);
      load_word(64'h0123456789ABCDEF, 1'b0, 8'h11);
      tick(); tick(); tick();
      load_word(64'hFEDCBA9876543210, 1'b0, 8'h22);
      drain("b2b");
      check("b2b_run", maxrun, 32'd16);
      check("b2b_overrun", {31'd0, OVERRUN}, 32'd0);

      // Overrun: three LOADs back to back with PIX_CE low. The third is dropped.
      PIX_CE = 1'b0;
      push_word(32'h11111111, 8'hA1);
      push_word(32'h22222222, 8'hA2);
      load_word(64'h11111111_00000000, 1'b0, 8'hA1);
      load_word(64'h22222222_00000000, 1'b0, 8'hA2);
      load_word(64'h33333333_00000000, 1'b0, 8'hA3);
      check("ovr_set",  {31'd0, OVERRUN},   32'd1);
      check("ovr_hold", {31'd0, HOLD_FULL}, 32'd1);
      check("ovr_busy", {31'd0, BUSY},      32'd1);
      CLR_OVR = 1'b1;
      tick();
      CLR_OVR = 1'b0;
      check("ovr_clear", {31'd0, OVERRUN}, 32'd0);
      // A drop in the same cycle as CLR_OVR leaves OVERRUN set.
      CLR_OVR = 1'b1;
      load_word(64'h44444444_00000000, 1'b0, 8'hA4);
      CLR_OVR = 1'b0;
      check("ovr_drop_wins", {31'd0, OVERRUN}, 32'd1);
      CLR_OVR = 1'b1;
      tick();
      CLR_OVR = 1'b0;
      check("ovr_clear2", {31'd0, OVERRUN}, 32'd0);
      PIX_CE = 1'b1;
      drain("ovr");

      // Sparse enable: PIX_CE every third cycle.
      PIX_CE = 1'b0;
      push_word(32'h89ABCDEF, 8'h3C);
      load_word(64'h89ABCDEF_01234567, 1'b0, 8'h3C);
      tick();
      check("sparse_busy", {31'd0, BUSY}, 32'd1);
      npix = 0;
      for (int k = 0; k < 30; k++) begin
         ce = (k % 3 == 0);
         PIX_CE = ce;
         tick();
         check("sparse_valid", {31'd0, PIX_VALID}, {31'd0, (ce && npix < 8)});
         if (PIX_VALID) npix++;
      end
      PIX_CE = 1'b0;
      check("sparse_count", npix, 32'd8);
      check("sparse_idle", {31'd0, BUSY}, 32'd0);
      tick();

      // Reset mid-word after three pixels.
      PIX_CE = 1'b1;
      push_word(32'h9ABCDEF1, 8'h77);
      load_word(64'h9ABCDEF1_00000000, 1'b0, 8'h77);
      tick(); tick(); tick(); tick();
      check("mid_valid", {31'd0, PIX_VALID}, 32'd1);
      check("mid_out",   {28'd0, PIX_OUT},   32'h0000000B);
      nRESET = 1'b0;
      @(negedge CLK);
      tick();
      q.delete();
      check("mrst_valid",   {31'd0, PIX_VALID},  32'd0);
      check("mrst_out",     {28'd0, PIX_OUT},    32'd0);
      check("mrst_pal",     {24'd0, PIX_PAL},    32'd0);
      check("mrst_opaque",  {31'd0, PIX_OPAQUE}, 32'd0);
      check("mrst_busy",    {31'd0, BUSY},       32'd0);
      check("mrst_hold",    {31'd0, HOLD_FULL},  32'd0);
      check("mrst_overrun", {31'd0, OVERRUN},    32'd0);
      // A LOAD during reset is ignored.
      load_word(64'h5555555500000000, 1'b0, 8'h55);
      nRESET = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         check("post_rst_valid", {31'd0, PIX_VALID}, 32'd0);
         check("post_rst_busy",  {31'd0, BUSY},      32'd0);
         check("post_rst_hold",  {31'd0, HOLD_FULL}, 32'd0);
      end

      // The block works normally again after reset.
      push_word(32'h01234567, 8'h5A);
      load_word(64'h0123456789ABCDEF, 1'b0, 8'h5A);
      drain("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
